// File: rtl/lift_motion_ctrl.sv
// lift_motion_ctrl
// ----------------
// Car motion controller for a 4-storey elevator. Takes the pending-request
// vector and the above/below need flags from the request processor and owns
// the car state (STOP / PAUSE / MOVE), the one-hot floor position, the run
// direction, the door-open dwell and the floor-to-floor travel time.
//
// Ports
//   clk        in   1  system clock, all state updates on posedge
//   rst        in   1  synchronous, active-high reset
//   allReq     in   4  pending requests, bit0 = floor 1
//   up_need    in   1  a request exists above the car
//   down_need  in   1  a request exists below the car
//   position   out  4  one-hot car floor (0001 = F1 .. 1000 = F4)
//   ud_mode    out  2  00 stop, 01 up, 10 down
//   state      out  3  000 STOP, 001 PAUSE, 010 MOVE
//   door_open  out  1  high exactly while state == PAUSE
//   arrive     out  1  one-cycle pulse on the cycle position changes
//
// All outputs come straight from flops; there is no input-to-output path.
module lift_motion_ctrl #(
    parameter int MOVE_TICKS  = 64,
    parameter int PAUSE_TICKS = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] allReq,
    input  logic       up_need,
    input  logic       down_need,
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic [2:0] state,
    output logic       door_open,
    output logic       arrive
);

    typedef enum logic [2:0] {
        ST_STOP  = 3'b000,
        ST_PAUSE = 3'b001,
        ST_MOVE  = 3'b010
    } state_t;

    localparam int MAX_TICKS = (MOVE_TICKS > PAUSE_TICKS) ? MOVE_TICKS : PAUSE_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [1:0] UD_STOP = 2'b00;
    localparam logic [1:0] UD_UP   = 2'b01;
    localparam logic [1:0] UD_DOWN = 2'b10;
    localparam logic [3:0] FLOOR_1 = 4'b0001;
    localparam logic [3:0] FLOOR_4 = 4'b1000;

    localparam logic [TW-1:0] MOVE_LAST  = TW'(MOVE_TICKS - 1);
    localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_TICKS - 1);

    state_t        state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic [1:0]    ud_q, ud_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          door_q, door_d;
    logic          arr_q, arr_d;

    logic [3:0]    np;
    logic          pos_onehot;
    logic          dir_need;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign pos_onehot = (pos_q != 4'd0) && ((pos_q & (pos_q - 4'd1)) == 4'd0);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        ud_d     = ud_q;
        tmr_d    = tmr_q;
        arr_d    = 1'b0;
        np       = pos_q;
        dir_need = 1'b0;

        if (!pos_onehot) begin
            // Corrupted position: park the car at floor 1.
            state_d = ST_STOP;
            pos_d   = FLOOR_1;
            ud_d    = UD_STOP;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                ST_STOP: begin
                    ud_d  = UD_STOP;
                    tmr_d = '0;
                    if ((allReq & pos_q) != 4'd0) begin
                        state_d = ST_PAUSE;
                    end else if (up_need && pos_q != FLOOR_4) begin
                        state_d = ST_MOVE;
                        ud_d    = UD_UP;
                    end else if (down_need && pos_q != FLOOR_1) begin
                        state_d = ST_MOVE;
                        ud_d    = UD_DOWN;
                    end
                end

                ST_MOVE: begin
                    if (ud_q != UD_UP && ud_q != UD_DOWN) begin
                        // A move without a direction cannot make progress.
                        state_d = ST_STOP;
                        pos_d   = FLOOR_1;
                        ud_d    = UD_STOP;
                        tmr_d   = '0;
                    end else if (tmr_q == MOVE_LAST) begin
                        np       = (ud_q == UD_UP) ? (pos_q << 1) : (pos_q >> 1);
                        pos_d    = np;
                        arr_d    = 1'b1;
                        tmr_d    = '0;
                        // Direction is frozen for the whole run; only the need in
                        // the travel direction can keep the car moving.
                        dir_need = (ud_q == UD_UP) ? (up_need && np != FLOOR_4)
                                                   : (down_need && np != FLOOR_1);
                        if ((allReq & np) != 4'd0) begin
                            state_d = ST_PAUSE;
                        end else if (dir_need) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_STOP;
                            ud_d    = UD_STOP;
                        end
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end

                ST_PAUSE: begin
                    if (tmr_q == PAUSE_LAST) begin
                        tmr_d = '0;
                        if (ud_q == UD_UP && up_need && pos_q != FLOOR_4) begin
                            state_d = ST_MOVE;
                        end else if (ud_q == UD_DOWN && down_need && pos_q != FLOOR_1) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_STOP;
                            ud_d    = UD_STOP;
                        end
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end

                default: begin
                    state_d = ST_STOP;
                    pos_d   = FLOOR_1;
                    ud_d    = UD_STOP;
                    tmr_d   = '0;
                end
            endcase
        end

        door_d = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_STOP;
            pos_q   <= FLOOR_1;
            ud_q    <= UD_STOP;
            tmr_q   <= '0;
            door_q  <= 1'b0;
            arr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            ud_q    <= ud_d;
            tmr_q   <= tmr_d;
            door_q  <= door_d;
            arr_q   <= arr_d;
        end
    end

    assign position  = pos_q;
    assign ud_mode   = ud_q;
    assign state     = state_q;
    assign door_open = door_q;
    assign arrive    = arr_q;

endmodule

// File: tb/tb_lift_motion_ctrl.sv
// Bench for lift_motion_ctrl with MOVE_TICKS=4, PAUSE_TICKS=3.
// The reference model tracks the car as an integer floor, a direction and a
// count of cycles left in the current phase, and is compared to the DUT
// every cycle. Directed checks with literal values pin the model.
module tb_lift_motion_ctrl;

    localparam int MT = 4;
    localparam int PT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] allReq;
    logic       up_need;
    logic       down_need;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic [2:0] state;
    logic       door_open;
    logic       arrive;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    lift_motion_ctrl #(.MOVE_TICKS(MT), .PAUSE_TICKS(PT)) dut (
        .clk       (clk),
        .rst       (rst),
        .allReq    (allReq),
        .up_need   (up_need),
        .down_need (down_need),
        .position  (position),
        .ud_mode   (ud_mode),
        .state     (state),
        .door_open (door_open),
        .arrive    (arrive)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: floor 1..4, dir 0 none / 1 up / 2 down,
    // phase 0 stopped / 1 door open / 2 travelling, left = cycles remaining.
    int         m_floor = 1;
    logic [1:0] m_dir   = 2'd0;
    int         m_phase = 0;
    int         m_left  = 0;
    logic       m_arr   = 1'b0;
    int         nf;

    always @(posedge clk) begin
        if (rst) begin
            m_floor <= 1;
            m_dir   <= 2'd0;
            m_phase <= 0;
            m_left  <= 0;
            m_arr   <= 1'b0;
        end else begin
            m_arr <= 1'b0;
            case (m_phase)
                0: begin
                    if (allReq[m_floor-1]) begin
                        m_phase <= 1; m_left <= PT;
                    end else if (up_need && m_floor < 4) begin
                        m_phase <= 2; m_left <= MT; m_dir <= 2'd1;
                    end else if (down_need && m_floor > 1) begin
                        m_phase <= 2; m_left <= MT; m_dir <= 2'd2;
                    end
                end
                2: begin
                    if (m_left > 1) begin
                        m_left <= m_left - 1;
                    end else begin
                        nf = (m_dir == 2'd1) ? m_floor + 1 : m_floor - 1;
                        m_floor <= nf;
                        m_arr   <= 1'b1;
                        if (allReq[nf-1]) begin
                            m_phase <= 1; m_left <= PT;
                        end else if ((m_dir == 2'd1 && up_need && nf < 4) ||
                                     (m_dir == 2'd2 && down_need && nf > 1)) begin
                            m_left <= MT;
                        end else begin
                            m_phase <= 0; m_dir <= 2'd0;
                        end
                    end
                end
                default: begin
                    if (m_left > 1) begin
                        m_left <= m_left - 1;
                    end else if ((m_dir == 2'd1 && up_need && m_floor < 4) ||
                                 (m_dir == 2'd2 && down_need && m_floor > 1)) begin
                        m_phase <= 2; m_left <= MT;
                    end else begin
                        m_phase <= 0; m_dir <= 2'd0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        logic [3:0] e_pos;
        logic [1:0] e_ud;
        #1;
        if (chk_en) begin
            e_pos = 4'b0001 << (m_floor - 1);
            e_ud  = (m_phase == 0) ? 2'd0 : m_dir;
            chk("m_position", position, e_pos);
            chk("m_ud_mode", {2'b0, ud_mode}, {2'b0, e_ud});
            chk("m_state", {1'b0, state}, 4'(m_phase));
            chk("m_door_open", {3'b0, door_open}, {3'b0, (m_phase == 1)});
            chk("m_arrive", {3'b0, arrive}, {3'b0, m_arr});
        end
    end

    initial begin
        rst = 1'b1; allReq = 4'b0; up_need = 1'b0; down_need = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(1);
        chk("rst_position", position, 4'b0001);
        chk("rst_state", {1'b0, state}, 4'd0);
        chk("rst_ud", {2'b0, ud_mode}, 4'd0);
        rst = 1'b0;

        // Idle
        tick(200);
        chk("idle_position", position, 4'b0001);
        chk("idle_state", {1'b0, state}, 4'd0);
        chk("idle_door", {3'b0, door_open}, 4'd0);

        // Run F1 -> F3
        allReq = 4'b0100; up_need = 1'b1;
        tick(1);
        chk("run_state_move", {1'b0, state}, 4'd2);
        chk("run_ud_up", {2'b0, ud_mode}, 4'd1);
        chk("run_pos_f1", position, 4'b0001);
        tick(4);
        chk("run_pos_f2", position, 4'b0010);
        chk("run_arrive_f2", {3'b0, arrive}, 4'd1);
        chk("run_pass_f2", {1'b0, state}, 4'd2);
        tick(4);
        chk("run_pos_f3", position, 4'b0100);
        chk("run_pause", {1'b0, state}, 4'd1);
        chk("run_door", {3'b0, door_open}, 4'd1);
        chk("run_pause_ud", {2'b0, ud_mode}, 4'd1);
        tick(2);
        chk("run_door_3rd", {3'b0, door_open}, 4'd1);
        allReq = 4'b0; up_need = 1'b0;
        tick(1);
        chk("run_stop", {1'b0, state}, 4'd0);
        chk("run_stop_ud", {2'b0, ud_mode}, 4'd0);
        chk("run_stop_door", {3'b0, door_open}, 4'd0);

        // Same-floor call
        rst = 1'b1; tick(1); rst = 1'b0;
        allReq = 4'b0001;
        tick(1);
        chk("same_pause", {1'b0, state}, 4'd1);
        chk("same_pos", position, 4'b0001);
        chk("same_door", {3'b0, door_open}, 4'd1);
        allReq = 4'b0;
        tick(2);
        chk("same_door_3rd", {3'b0, door_open}, 4'd1);
        tick(1);
        chk("same_stop", {1'b0, state}, 4'd0);
        chk("same_door_off", {3'b0, door_open}, 4'd0);

        // End-floor guard
        allReq = 4'b1000; up_need = 1'b1;
        tick(1);
        tick(12);
        chk("top_pos", position, 4'b1000);
        chk("top_pause", {1'b0, state}, 4'd1);
        allReq = 4'b0; up_need = 1'b0;
        tick(3);
        chk("top_stop", {1'b0, state}, 4'd0);
        up_need = 1'b1;
        repeat (20) begin
            tick(1);
            chk("guard_arrive", {3'b0, arrive}, 4'd0);
            chk("guard_state", {1'b0, state}, 4'd0);
        end
        chk("guard_pos", position, 4'b1000);
        up_need = 1'b0;

        // Tie and reverse
        rst = 1'b1; tick(1); rst = 1'b0;
        allReq = 4'b0010; up_need = 1'b1;
        tick(5);
        chk("tie_at_f2", position, 4'b0010);
        allReq = 4'b0; up_need = 1'b0;
        tick(3);
        chk("tie_stop_f2", {1'b0, state}, 4'd0);
        up_need = 1'b1; down_need = 1'b1; allReq = 4'b1000;
        tick(1);
        chk("tie_move", {1'b0, state}, 4'd2);
        chk("tie_ud_up", {2'b0, ud_mode}, 4'd1);
        tick(8);
        chk("tie_pos_f4", position, 4'b1000);
        chk("tie_pause_f4", {1'b0, state}, 4'd1);
        up_need = 1'b0; down_need = 1'b1; allReq = 4'b0001;
        tick(3);
        chk("rev_stop", {1'b0, state}, 4'd0);
        chk("rev_stop_ud", {2'b0, ud_mode}, 4'd0);
        tick(1);
        chk("rev_move", {1'b0, state}, 4'd2);
        chk("rev_ud_down", {2'b0, ud_mode}, 4'd2);

        // Reset mid-move at F3 with the timer at 2
        tick(6);
        chk("mid_pos_f3", position, 4'b0100);
        chk("mid_state", {1'b0, state}, 4'd2);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_pos", position, 4'b0001);
        chk("mid_rst_state", {1'b0, state}, 4'd0);
        chk("mid_rst_ud", {2'b0, ud_mode}, 4'd0);
        chk("mid_rst_door", {3'b0, door_open}, 4'd0);
        chk("mid_rst_arrive", {3'b0, arrive}, 4'd0);
        rst = 1'b0; allReq = 4'b0; down_need = 1'b0;
        tick(5);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
